qracc_sram_bank_arbiter: RTL
============================

Name: qracc_sram_bank_arbiter

Overview:
- Parametrised multi-bank SRAM front-end. It takes one sram_itf-style request stream and steers it to NUM_BANKS independent bank slave ports.
- It adds three things the single-bank handshake lacks: broadcast writes to one row of all banks, multiple outstanding reads across banks, and in-order read return with downstream backpressure.
- It sits between the QRAcc controller/data interface and the per-bank column SRAM wrappers.

Parameters:
- NUM_BANKS, 8, number of bank ports (power of two, >=2).
- NUM_ROWS, 128, rows per bank.
- NUM_COLS, 32, word width per bank.
- MAX_OUTSTANDING, 4, depth of the read-order FIFO (power of two, <= NUM_BANKS).
- Derived: RA = $clog2(NUM_ROWS), BA = $clog2(NUM_BANKS).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- rq_valid_i  in  1  request valid
- rq_ready_o  out  1  request accepted when valid & ready
- rq_wr_i  in  1  1 = write, 0 = read
- rq_bcast_i  in  1  broadcast write to row rq_addr_i[RA-1:0] of all banks
- rq_addr_i  in  BA+RA  {bank, row}
- rq_wdata_i  in  NUM_COLS  write data
- rd_valid_o  out  1  read response valid
- rd_ready_i  in  1  downstream ready for response
- rd_data_o  out  NUM_COLS  read response data
- bank_rq_valid_o  out  NUM_BANKS  per-bank request valid
- bank_rq_wr_o  out  NUM_BANKS  per-bank write flag
- bank_addr_o  out  NUM_BANKS*RA  per-bank row address, bank b at [b*RA +: RA]
- bank_wdata_o  out  NUM_BANKS*NUM_COLS  per-bank write data
- bank_rq_ready_i  in  NUM_BANKS  per-bank request ready
- bank_rd_valid_i  in  NUM_BANKS  per-bank read data valid (one pulse per accepted read)
- bank_rd_data_i  in  NUM_BANKS*NUM_COLS  per-bank read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  reads accepted but not yet returned
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (nrst low, async): all outputs 0, FSM = IDLE, order FIFO empty, all busy/hold flags cleared, err_o = 0. A reset mid-operation drops pending broadcasts and reads without generating responses.
- FSM states: IDLE, BCAST.
- IDLE, single-bank request (rq_bcast_i = 0), with b = rq_addr_i[BA+RA-1:RA]:
  - Combinational pass-through: bank_rq_valid_o[b] = rq_valid_i & allow; other banks 0.
  - bank_addr_o/bank_wdata_o for bank b carry the row and data; rq_ready_o = bank_rq_ready_i[b] & allow.
  - Writes: allow = 1.
  - Reads: allow = ~busy[b] & ~fifo_full.
- Read accept: push b into order FIFO and set busy[b] on the next edge. Result: at most one outstanding read per bank and at most MAX_OUTSTANDING in total.
- IDLE, broadcast with rq_wr_i = 1:
  - rq_ready_o = 1 combinationally; no bank is driven this cycle.
  - Latch row and data, set pend = all ones, go to BCAST.
- BCAST:
  - bank_rq_valid_o = pend, bank_rq_wr_o = all ones; every bank gets the latched row/data.
  - Clear pend[b] on bank_rq_ready_i[b]. rq_ready_o = 0.
  - Return to IDLE on the edge where the remaining pend bits all handshake; a new request is accepted from the following cycle.
  - The read path keeps operating during BCAST.
- Broadcast with rq_wr_i = 0 is illegal: accept it (rq_ready_o = 1), issue nothing, set err_o.
- Response capture: on bank_rd_valid_i[b] with busy[b] & ~hold[b], capture data into hold_data[b] and set hold[b]. A bank_rd_valid_i[b] arriving while ~busy[b] or hold[b] is ignored and sets err_o.
- Response output:
  - rd_valid_o = ~fifo_empty & hold[head]; rd_data_o = hold_data[head].
  - Same cycle as a capture into the head bank, rd_valid_o stays 0 (registered hold).
  - On rd_valid_o & rd_ready_i: pop the FIFO, clear hold[head] and busy[head].
  - A new read to that bank is accepted from the next cycle, not the pop cycle.
  - rd_valid_o/rd_data_o stay stable while rd_ready_i = 0.
- Ordering: responses return in read-accept order regardless of bank completion order. Write/read order within a bank is preserved by issue order.
- Simultaneous push and pop: outstanding_o is unchanged. The FIFO pointers wrap modulo MAX_OUTSTANDING. fifo_full is determined by count == MAX_OUTSTANDING.
- Minimum read latency: bank response cycle + 1 to rd_valid_o.

Test Plan:
- Write 0xA5A5_0001 to bank 3 row 10, then read it with bank latency 2 -> rd_valid_o 3 cycles after the bank accept, rd_data_o = 0xA5A5_0001, outstanding_o returns to 0.
- Broadcast write 0x1234_5678 to row 5, with bank 2 ready delayed 4 cycles -> rq_ready_o low until pend clears; all 8 banks written exactly once; reads of row 5 in every bank return 0x1234_5678.
- Reads to banks 0,1,2,3 back-to-back, banks responding in order 3,2,1,0 -> responses emitted in order 0,1,2,3 with the correct data; a fifth read is stalled (rq_ready_o = 0) until the first pop.
- Second read to a busy bank 4 -> rq_ready_o held 0 until the cycle after bank 4's response pops; a read to bank 5 in the meantime is accepted.
- rd_ready_i held low 6 cycles with a valid response -> rd_valid_o/rd_data_o stable; no pop; outstanding_o constant.
- Broadcast read and a spurious bank_rd_valid_i[7] -> err_o sets and stays 1; nrst pulse mid-BCAST -> all outputs 0, FSM IDLE, err_o cleared.

Source files
------------

// File: rtl/qracc_sram_bank_arbiter.sv
// Multi-bank SRAM front-end: steers one request stream to NUM_BANKS bank ports.
// It also does broadcast row writes and returns multi-bank reads in accept order.
//
// state | meaning
// IDLE  | pass single-bank requests through; a broadcast write latches and goes to BCAST
// BCAST | drive latched row/data to every bank whose pend bit is still set
module qracc_sram_bank_arbiter #(
    parameter int NUM_BANKS       = 8,
    parameter int NUM_ROWS        = 128,
    parameter int NUM_COLS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int RA = $clog2(NUM_ROWS),
    localparam int BA = $clog2(NUM_BANKS),
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          rq_valid_i,
    output logic                          rq_ready_o,
    input  logic                          rq_wr_i,
    input  logic                          rq_bcast_i,
    input  logic [BA+RA-1:0]              rq_addr_i,
    input  logic [NUM_COLS-1:0]           rq_wdata_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [NUM_COLS-1:0]           rd_data_o,
    output logic [NUM_BANKS-1:0]          bank_rq_valid_o,
    output logic [NUM_BANKS-1:0]          bank_rq_wr_o,
    output logic [NUM_BANKS*RA-1:0]       bank_addr_o,
    output logic [NUM_BANKS*NUM_COLS-1:0] bank_wdata_o,
    input  logic [NUM_BANKS-1:0]          bank_rq_ready_i,
    input  logic [NUM_BANKS-1:0]          bank_rd_valid_i,
    input  logic [NUM_BANKS*NUM_COLS-1:0] bank_rd_data_i,
    output logic [OW-1:0]                 outstanding_o,
    output logic                          err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, BCAST} state_t;

    state_t                state_q, state_d;
    logic [NUM_BANKS-1:0]  pend_q, pend_d;
    logic [RA-1:0]         bc_row_q;
    logic [NUM_COLS-1:0]   bc_data_q;
    logic                  bc_latch;

    logic [NUM_BANKS-1:0]  busy_q, hold_q;
    logic [NUM_COLS-1:0]   hold_data_q [NUM_BANKS];
    logic [BA-1:0]         fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]         count_q;
    logic                  err_q;

    logic [BA-1:0]         rq_bank;
    logic [RA-1:0]         rq_row;
    logic [BA-1:0]         head;
    logic                  fifo_full, fifo_empty;
    logic                  allow, push, pop, bcast_err;
    logic [NUM_BANKS-1:0]  cap, spur, push_mask, pop_mask;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rq_bank    = rq_addr_i[BA+RA-1:RA];
    assign rq_row     = rq_addr_i[RA-1:0];
    assign fifo_full  = (count_q == OW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // hold is registered, so a capture into the head bank shows up one cycle later
    assign rd_valid_o    = ~fifo_empty & hold_q[head];
    assign rd_data_o     = hold_data_q[head];
    assign pop           = rd_valid_o & rd_ready_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    assign push_mask = push ? (NUM_BANKS'(1) << rq_bank) : '0;
    assign pop_mask  = pop  ? (NUM_BANKS'(1) << head)    : '0;

    always_comb begin
        cap  = '0;
        spur = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            cap[b]  = bank_rd_valid_i[b] & busy_q[b] & ~hold_q[b];
            spur[b] = bank_rd_valid_i[b] & ~cap[b];
        end
    end

    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        bc_latch        = 1'b0;
        push            = 1'b0;
        bcast_err       = 1'b0;
        allow           = 1'b0;
        rq_ready_o      = 1'b0;
        bank_rq_valid_o = '0;
        bank_rq_wr_o    = '0;
        bank_addr_o     = '0;
        bank_wdata_o    = '0;
        case (state_q)
            IDLE: begin
                if (rq_bcast_i) begin
                    rq_ready_o = 1'b1;
                    if (rq_valid_i) begin
                        if (rq_wr_i) begin
                            bc_latch = 1'b1;
                            pend_d   = '1;
                            state_d  = BCAST;
                        end else begin
                            bcast_err = 1'b1;
                        end
                    end
                end else begin
                    allow = rq_wr_i | (~busy_q[rq_bank] & ~fifo_full);
                    bank_rq_valid_o[rq_bank] = rq_valid_i & allow;
                    bank_rq_wr_o[rq_bank]    = rq_wr_i;
                    bank_addr_o[int'(rq_bank)*RA +: RA]              = rq_row;
                    bank_wdata_o[int'(rq_bank)*NUM_COLS +: NUM_COLS] = rq_wdata_i;
                    rq_ready_o = bank_rq_ready_i[rq_bank] & allow;
                    push       = rq_valid_i & rq_ready_o & ~rq_wr_i;
                end
            end
            BCAST: begin
                bank_rq_valid_o = pend_q;
                bank_rq_wr_o    = '1;
                bank_addr_o     = {NUM_BANKS{bc_row_q}};
                bank_wdata_o    = {NUM_BANKS{bc_data_q}};
                pend_d          = pend_q & ~bank_rq_ready_i;
                if (pend_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            bc_row_q  <= '0;
            bc_data_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (bc_latch) begin
                bc_row_q  <= rq_row;
                bc_data_q <= rq_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q   <= '0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
            for (int b = 0; b < NUM_BANKS; b++) hold_data_q[b] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rq_bank;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            busy_q <= (busy_q | push_mask) & ~pop_mask;
            hold_q <= (hold_q | cap) & ~pop_mask;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (cap[b]) hold_data_q[b] <= bank_rd_data_i[b*NUM_COLS +: NUM_COLS];
            end
            err_q <= err_q | bcast_err | (|spur);
        end
    end

endmodule
